// File: rtl/count_event_monitor_pkg.sv
// Package: count_evt_pkg
// Shared types and default widths for the count event monitor.
//   evt_type_e : 2-bit event type carried in every queued record
//   evt_rec_t  : packed record layout {type, count, wraps}
//   EVT_W      : width of a packed record
//   evt_type_f : builds the event type from the match/wrap detections
package count_evt_pkg;

    localparam int unsigned DEF_CNT_W      = 4;
    localparam int unsigned DEF_WRAP_W     = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned EVT_W          = 2 + DEF_CNT_W + DEF_WRAP_W;

    typedef enum logic [1:0] {
        EVT_NONE  = 2'b00,
        EVT_MATCH = 2'b01,
        EVT_WRAP  = 2'b10,
        EVT_BOTH  = 2'b11
    } evt_type_e;

    typedef struct packed {
        evt_type_e                 evt_type;
        logic [DEF_CNT_W-1:0]      count;
        logic [DEF_WRAP_W-1:0]     wraps;
    } evt_rec_t;

    // Bit 1 flags a wrap, bit 0 a match, so both together encode EVT_BOTH.
    function automatic evt_type_e evt_type_f(input logic match, input logic wrap);
        return evt_type_e'({wrap, match});
    endfunction

endpackage

// File: rtl/count_event_monitor_if.sv
// Interface: count_event_monitor_if
// Valid/ready event stream from the monitor to its consumer.
//   evt_valid : record at the head of the queue is valid (master -> slave)
//   evt_ready : consumer accepts the head record        (slave -> master)
//   evt_data  : packed record {type, count, wraps}       (master -> slave)
interface count_event_monitor_if #(
    parameter int unsigned DataW = 14
);

    logic             evt_valid;
    logic             evt_ready;
    logic [DataW-1:0] evt_data;

    modport master (
        output evt_valid,
        output evt_data,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_data,
        output evt_ready
    );

endinterface

// File: rtl/count_event_monitor_evt_fifo.sv
// Module: evt_fifo
// Synchronous register-array FIFO holding event records.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high flush
//   push_i  : write wdata_i (ignored when full unless a pop happens this cycle)
//   wdata_i : record to write
//   pop_i   : remove the head (ignored when empty)
//   full_o  : DEPTH entries held
//   empty_o : no entries held
//   head_o  : head record; holds the last popped record while empty
module evt_fifo #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        // A full FIFO can still take a write when its head leaves this cycle.
        do_push  = push_i && (!full_o || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            // Power-of-two depth lets the pointer wrap naturally.
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

    // Storage needs no reset: it is only visible through valid pointers.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/count_event_monitor.sv
// Module: count_event_monitor
// Watches an upstream counter, detects wrap-around (max -> 0) and matches against a
// programmable compare value, counts wraps, and queues event records in a FIFO.
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset, overrides everything
//   count_in    : sampled counter value
//   cmp_value   : match compare value
//   cmp_en      : enables match detection
//   evt         : master side of the event stream {evt_valid, evt_ready, evt_data}
//   wrap_cnt    : total wraps seen, modulo 2^WRAP_W
//   match_pulse : one-cycle pulse the cycle after a match
//   drop_flag   : sticky, an event was lost to a full FIFO
module count_event_monitor
    import count_evt_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned WRAP_W     = DEF_WRAP_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CNT_W-1:0]             count_in,
    input  logic [CNT_W-1:0]             cmp_value,
    input  logic                         cmp_en,
    count_event_monitor_if.master        evt,
    output logic [WRAP_W-1:0]            wrap_cnt,
    output logic                         match_pulse,
    output logic                         drop_flag
);

    localparam int unsigned RecW = 2 + CNT_W + WRAP_W;

    logic [CNT_W-1:0]  prev_count_q, prev_count_d;
    logic              prev_valid_q, prev_valid_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              match_pulse_q, match_pulse_d;
    logic              drop_flag_q, drop_flag_d;

    logic              is_wrap, is_match, has_evt;
    evt_type_e         evt_type;
    logic [RecW-1:0]   rec;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [RecW-1:0]   fifo_head;

    always_comb begin
        // prev_valid gates wrap so the first sample after reset is history only.
        is_wrap  = prev_valid_q && (prev_count_q == {CNT_W{1'b1}}) && (count_in == '0);
        // A held count matches only on the cycle it first appears.
        is_match = cmp_en && (count_in == cmp_value) &&
                   (!prev_valid_q || (count_in != prev_count_q));
        evt_type = evt_type_f(is_match, is_wrap);
        has_evt  = (evt_type != EVT_NONE);

        wrap_cnt_d = wrap_cnt_q + WRAP_W'(is_wrap);
        // The record carries the wrap count including this cycle's wrap.
        rec        = {evt_type, count_in, wrap_cnt_d};

        fifo_pop    = !fifo_empty && evt.evt_ready;
        fifo_push   = has_evt && (!fifo_full || fifo_pop);
        drop_flag_d = drop_flag_q || (has_evt && fifo_full && !fifo_pop);

        prev_count_d  = count_in;
        prev_valid_d  = 1'b1;
        match_pulse_d = is_match;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_count_q  <= '0;
            prev_valid_q  <= 1'b0;
            wrap_cnt_q    <= '0;
            match_pulse_q <= 1'b0;
            drop_flag_q   <= 1'b0;
        end else begin
            prev_count_q  <= prev_count_d;
            prev_valid_q  <= prev_valid_d;
            wrap_cnt_q    <= wrap_cnt_d;
            match_pulse_q <= match_pulse_d;
            drop_flag_q   <= drop_flag_d;
        end
    end

    evt_fifo #(
        .WIDTH (RecW),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .wdata_i (rec),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_data  = fifo_head;
    assign wrap_cnt      = wrap_cnt_q;
    assign match_pulse   = match_pulse_q;
    assign drop_flag     = drop_flag_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// Testbench for count_event_monitor: vector table, directed corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_count_event_monitor;
    import count_evt_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cnt = '0;
    logic [3:0] cmp = '0;
    logic       en  = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] wrap_cnt;
    logic       match_pulse, drop_flag;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    count_event_monitor_if #(.DataW(EVT_W)) evt_bus ();
    assign evt_bus.evt_ready = rdy;

    count_event_monitor dut (
        .clk         (clk),
        .reset       (rst),
        .count_in    (cnt),
        .cmp_value   (cmp),
        .cmp_en      (en),
        .evt         (evt_bus),
        .wrap_cnt    (wrap_cnt),
        .match_pulse (match_pulse),
        .drop_flag   (drop_flag)
    );

    // Reference model: queue of pending records plus the last sample.
    logic [13:0] mq[$];
    logic [3:0]  m_prev;
    bit          m_have_prev;
    int          m_wraps;
    bit          m_pulse;
    bit          m_drop;

    function automatic logic [13:0] rec(input logic [1:0] t, input logic [3:0] c,
                                        input logic [7:0] w);
        return {t, c, w};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model with the current inputs, clock the DUT, compare.
    task automatic cycle();
        bit pop, w, m;
        if (rst) begin
            mq.delete();
            m_have_prev = 0;
            m_prev      = '0;
            m_wraps     = 0;
            m_pulse     = 0;
            m_drop      = 0;
        end else begin
            pop = (mq.size() > 0) && rdy;
            w   = m_have_prev && (m_prev == 4'hF) && (cnt == 4'h0);
            m   = en && (cnt == cmp) && (!m_have_prev || cnt != m_prev);
            m_wraps = (m_wraps + (w ? 1 : 0)) % 256;
            if (pop) void'(mq.pop_front());
            if (w || m) begin
                if (mq.size() < 4) mq.push_back({w, m, cnt, 8'(m_wraps)});
                else m_drop = 1;
            end
            m_prev      = cnt;
            m_have_prev = 1;
            m_pulse     = m;
        end
        @(posedge clk);
        #1;
        check("evt_valid", 32'(evt_bus.evt_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) check("evt_data", 32'(evt_bus.evt_data), 32'(mq[0]));
        if (rst) check("evt_data_rst", 32'(evt_bus.evt_data), 32'd0);
        check("wrap_cnt", 32'(wrap_cnt), 32'(m_wraps));
        check("match_pulse", 32'(match_pulse), 32'(m_pulse));
        check("drop_flag", 32'(drop_flag), 32'(m_drop));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  cnt;
        logic [3:0]  cmp;
        logic        en;
        logic        rdy;
        logic        ev;
        logic [13:0] ed;
        logic [7:0]  ew;
        logic        ep;
        logic        edrop;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int n;

        // Held match, same-cycle wrap+match, and the match right after reset.
        vecs[0]  = '{1'b1, 4'd0,  4'd5, 1'b1, 1'b1, 1'b0, 14'd0,             8'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'd4,  4'd5, 1'b1, 1'b1, 1'b0, 14'd0,             8'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'd5,  4'd5, 1'b1, 1'b1, 1'b1, rec(2'b01, 5, 0),  8'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'd5,  4'd5, 1'b1, 1'b1, 1'b0, 14'd0,             8'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'd5,  4'd5, 1'b1, 1'b1, 1'b0, 14'd0,             8'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd15, 4'd0, 1'b1, 1'b1, 1'b0, 14'd0,             8'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'd0,  4'd0, 1'b1, 1'b1, 1'b1, rec(2'b11, 0, 1),  8'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'd0,  4'd0, 1'b1, 1'b1, 1'b0, 14'd0,             8'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'd1,  4'd0, 1'b1, 1'b1, 1'b0, 14'd0,             8'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'd15, 4'd0, 1'b1, 1'b1, 1'b0, 14'd0,             8'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'd0,  4'd0, 1'b1, 1'b1, 1'b1, rec(2'b01, 0, 0),  8'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b1, rec(2'b01, 0, 0),  8'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'd1,  4'd0, 1'b1, 1'b1, 1'b0, 14'd0,             8'd0, 1'b0, 1'b0};

        // Count 0..15,0 without match detection: exactly one wrap record.
        do_reset();
        en  = 1'b0;
        rdy = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cnt = 4'(c);
            cycle();
        end
        cnt = 4'd0;
        cycle();
        check("t1_valid", 32'(evt_bus.evt_valid), 32'd1);
        check("t1_data", 32'(evt_bus.evt_data), 32'(rec(EVT_WRAP, 0, 1)));
        check("t1_wrap_cnt", 32'(wrap_cnt), 32'd1);
        check("t1_pulse", 32'(match_pulse), 32'd0);
        cnt = 4'd1;
        cycle();
        check("t1_drained", 32'(evt_bus.evt_valid), 32'd0);

        // Vector table.
        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst;
            cnt = vecs[i].cnt;
            cmp = vecs[i].cmp;
            en  = vecs[i].en;
            rdy = vecs[i].rdy;
            cycle();
            check($sformatf("vec%0d_valid", i), 32'(evt_bus.evt_valid), 32'(vecs[i].ev));
            if (vecs[i].ev) check($sformatf("vec%0d_data", i), 32'(evt_bus.evt_data),
                                  32'(vecs[i].ed));
            check($sformatf("vec%0d_wrap", i), 32'(wrap_cnt), 32'(vecs[i].ew));
            check($sformatf("vec%0d_pulse", i), 32'(match_pulse), 32'(vecs[i].ep));
            check($sformatf("vec%0d_drop", i), 32'(drop_flag), 32'(vecs[i].edrop));
        end
        rst = 1'b0;

        // Five events with ready low: four held, fifth dropped, then in-order drain.
        en = 1'b0;
        do_reset();
        rdy = 1'b0;
        cnt = 4'd15;
        cycle();
        for (int k = 1; k <= 5; k++) begin
            cnt = 4'd0;
            cycle();
            check("t4_hold_data", 32'(evt_bus.evt_data), 32'(rec(EVT_WRAP, 0, 1)));
            cnt = 4'd15;
            cycle();
        end
        check("t4_drop", 32'(drop_flag), 32'd1);
        check("t4_wrap_cnt", 32'(wrap_cnt), 32'd5);
        cnt = 4'd5;
        rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t4_drain_valid", 32'(evt_bus.evt_valid), 32'd1);
            check("t4_drain_data", 32'(evt_bus.evt_data), 32'(rec(EVT_WRAP, 0, 8'(i))));
            cycle();
        end
        check("t4_empty", 32'(evt_bus.evt_valid), 32'd0);
        check("t4_drop_sticky", 32'(drop_flag), 32'd1);

        // Full FIFO with push and pop in the same cycle.
        do_reset();
        rdy = 1'b0;
        cnt = 4'd15;
        cycle();
        for (int k = 1; k <= 4; k++) begin
            cnt = 4'd0;
            cycle();
            cnt = 4'd15;
            cycle();
        end
        cnt = 4'd0;
        rdy = 1'b1;
        cycle();
        check("t5_drop", 32'(drop_flag), 32'd0);
        cnt = 4'd1;
        n = 0;
        while (evt_bus.evt_valid && n < 10) begin
            check("t5_order", 32'(evt_bus.evt_data), 32'(rec(EVT_WRAP, 0, 8'(n + 2))));
            cycle();
            n++;
        end
        check("t5_occupancy", 32'(n), 32'd4);

        // Reset with three queued records and wrap_cnt=7.
        do_reset();
        rdy = 1'b1;
        cnt = 4'd15;
        cycle();
        for (int k = 1; k <= 7; k++) begin
            if (k == 5) rdy = 1'b0;
            cnt = 4'd0;
            cycle();
            cnt = 4'd15;
            cycle();
        end
        check("t6_wrap7", 32'(wrap_cnt), 32'd7);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_valid", 32'(evt_bus.evt_valid), 32'd0);
        check("t6_data", 32'(evt_bus.evt_data), 32'd0);
        check("t6_wrap", 32'(wrap_cnt), 32'd0);
        cnt = 4'd0;
        cycle();
        check("t6_no_wrap", 32'(wrap_cnt), 32'd0);
        check("t6_no_evt", 32'(evt_bus.evt_valid), 32'd0);

        // 256 wraps roll the wrap counter back to 0.
        do_reset();
        rdy = 1'b1;
        cnt = 4'd15;
        cycle();
        for (int k = 1; k <= 256; k++) begin
            cnt = 4'd0;
            cycle();
            if (k == 255) check("t7_wrap255", 32'(wrap_cnt), 32'd255);
            if (k == 256) begin
                check("t7_wrap_roll", 32'(wrap_cnt), 32'd0);
                check("t7_rec_roll", 32'(evt_bus.evt_data), 32'(rec(EVT_WRAP, 0, 0)));
            end
            cnt = 4'd15;
            cycle();
        end

        // Randomized run, mostly counting with occasional jumps and resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(99) == 0);
            if ($urandom_range(9) < 7) cnt = cnt + 4'd1;
            else cnt = 4'($urandom_range(15));
            if ($urandom_range(15) == 0) cmp = 4'($urandom_range(15));
            en  = ($urandom_range(3) != 0);
            rdy = ($urandom_range(1) == 1);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
